gaplus_input_cond: RTL and testbench
====================================

// Module: gaplus_input_cond
// PURPOSE
//  Input-conditioning stage directly upstream of the FPGA_GAPLUS core's INP0/INP1/INP2 ports.
//  - Decodes PS/2 key events and merges them with both HPS joysticks.
//  - Applies the orientation remap to both sticks.
//  - Shapes coin inserts into frame-timed pulses that the core's custom I/O chip reliably
//    counts, queueing rapid inserts so none are lost.
// PARAMETERS
//  COIN_HOLD  default 3  frames the coin line is held high per credit (1..15)
//  COIN_GAP   default 3  frames the coin line is held low between queued credits (1..15)
//  PEND_MAX   default 7  saturation limit of the pending-credit counter (1..15)
// PORTS
//  MCLK     in   1   system clock; every register is in this domain
//  RESET    in   1   asynchronous, active-high reset
//  ps2_key  in   11  [10] event toggle, [9] pressed, [8:0] extended scan code
//  joystk1  in   16  HPS joystick 1: [0]R [1]L [2]D [3]U [4]fire [5]start1 [6]start2 [7]coin
//  joystk2  in   16  HPS joystick 2, same layout as joystk1
//  ORIENT   in   1   1 = horizontal display; stick nibble {L,D,R,U} becomes {D,R,U,L}
//  VBLK     in   1   vertical blank from the video timing generator (synchronous to MCLK)
//  INP0     out  5   {fire1, L1, D1, R1, U1} after orientation remap
//  INP1     out  5   {fire2, L2, D2, R2, U2} after orientation remap
//  INP2     out  3   {coin_pulse, start2, start1}
// BEHAVIOUR
//  Reset: all key registers, the edge detectors, the pending counter, the frame counter
//    and INP0/INP1/INP2 go to 0; the coin FSM goes to IDLE.
//    Reset asserted mid-pulse drops the coin line at once and discards the queue.
//  Key decode:
//    - A key event is ps2_key[10] differing from its 1-cycle-delayed copy.
//    - On an event, the matched key register takes ps2_key[9]; unmatched codes are ignored.
//    - Codes: arrows X75/X72/X6B/X74; space 029 and ctrl 014 = fire1; F1 005; F2 006;
//      1 016, 2 01E, 5 02E, 6 036; R/F/D/G = P2 directions; A/S = fire2.
//    - The delayed toggle copy resets to 0, so a toggle already at 1 when reset is released
//      produces one spurious event in the first cycle; that event is decoded like any other.
//  Merge:
//    - P2 controls are OR'd into P1 (upright cabinet only).
//    - start1 = F1 | key1 | joy1[5] | joy2[5]; start2 likewise with F2, key2 and [6].
//    - coin_raw = F1 | F2 | key5 | key6 | joy1[7] | joy2[7].
//  Outputs are registered: 1 cycle from key-register update or joystick change to INP*.
//  Frame tick: 1-cycle strobe on each VBLK 0->1 edge.
//  Coin queue:
//    - A coin_raw rising edge increments pend, saturating at PEND_MAX.
//    - A dequeue decrements pend. A same-cycle insert and dequeue leave pend unchanged.
//  Coin FSM (fcnt = frame counter):
//    IDLE: coin=0. If pend>0 (or a same-cycle insert): dequeue, fcnt<=0, go HOLD.
//    HOLD: coin=1. Each tick fcnt++. At fcnt==COIN_HOLD-1 with a tick: fcnt<=0, go GAP.
//    GAP : coin=0. Each tick fcnt++. At fcnt==COIN_GAP-1 with a tick: fcnt<=0, then
//          dequeue and go HOLD if pend>0, else go IDLE.
//  With VBLK stuck at 0 the FSM stays in its current state; inserts keep queueing.
//  A held coin key counts once; releasing and re-pressing it counts again.
// CONFIGURATION
//  INPUT_SOCD_EN defined: per player, after merging and before rotation, U&D both set
//    forces both to 0, and L&R both set forces both to 0.
//  INPUT_SOCD_EN undefined: opposing directions pass through unchanged.
// STRUCTURE
//  Package gaplus_input_pkg:
//    - localparam scan codes for every mapped key.
//    - typedef enum logic [1:0] {CQ_IDLE, CQ_HOLD, CQ_GAP} coin_state_t.
//    - function stkrot(orient, stk[3:0]).
//  Sub-module gaplus_coin_queue (MCLK, RESET, tick, coin_edge -> coin_pulse):
//    holds pend, fcnt and the FSM.
//  Top level holds the PS/2 decode, the merge, the optional SOCD stage and the output registers.
// TESTING
//  1. Reset mid-HOLD (pend=2) -> INP2[2] is 0 in the same cycle as RESET rises; after
//     release the FSM is IDLE, pend=0 and no further pulse occurs.
//  2. Set ps2_key=0x075 with [9]=1 and toggle [10] -> INP0[0]=1 after 2 MCLK. Toggle again
//     with [9]=0 -> INP0[0]=0. Same code with no toggle -> no change.
//  3. joy1[7] pulse for 1 cycle, defaults, VBLK period 100 cycles -> INP2[2] high exactly
//     3 ticks; 3 more ticks later the FSM is IDLE and INP2[2] low.
//  4. Ten coin edges within one frame -> pend saturates at 7; exactly 8 pulses emitted
//     (first dequeued immediately), each 3 frames high with 3 frames low between them.
//  5. ORIENT=1 with only U1 pressed -> INP0[3:0]=4'b1000; ORIENT=0 -> 4'b0001.
//  6. INPUT_SOCD_EN defined: U1 and D1 pressed -> INP0[2]=INP0[0]=0. Undefined: both read 1.

Source files
------------

// File: rtl/gaplus_input_cond_pkg.sv
// gaplus_input_pkg: scan codes, coin FSM states and stick rotation helper shared by the input conditioner
package gaplus_input_pkg;
  localparam logic [7:0] SC_UP = 8'h75;
  localparam logic [7:0] SC_DN = 8'h72;
  localparam logic [7:0] SC_LF = 8'h6B;
  localparam logic [7:0] SC_RT = 8'h74;
  localparam logic [8:0] SC_SPACE = 9'h029;
  localparam logic [8:0] SC_CTRL = 9'h014;
  localparam logic [8:0] SC_F1 = 9'h005;
  localparam logic [8:0] SC_F2 = 9'h006;
  localparam logic [8:0] SC_1 = 9'h016;
  localparam logic [8:0] SC_2 = 9'h01E;
  localparam logic [8:0] SC_5 = 9'h02E;
  localparam logic [8:0] SC_6 = 9'h036;
  localparam logic [8:0] SC_R = 9'h02D;
  localparam logic [8:0] SC_F = 9'h02B;
  localparam logic [8:0] SC_D = 9'h023;
  localparam logic [8:0] SC_G = 9'h034;
  localparam logic [8:0] SC_A = 9'h01C;
  localparam logic [8:0] SC_S = 9'h01B;
  typedef enum logic [1:0] {CQ_IDLE, CQ_HOLD, CQ_GAP} coin_state_t;
  // stk is {L,D,R,U}; horizontal mode relabels U->L, L->D, D->R, R->U
  function automatic logic [3:0] stkrot(input logic orient, input logic [3:0] stk);
    return orient ? {stk[0], stk[3:1]} : stk;
  endfunction
endpackage

// File: rtl/gaplus_input_cond_if.sv
// gaplus_input_cond_if: raw HPS/PS2 inputs and conditioned INP0..INP2 bus toward the Gaplus core
interface gaplus_input_cond_if;
  logic [10:0] ps2_key;
  logic [15:0] joystk1;
  logic [15:0] joystk2;
  logic ORIENT;
  logic VBLK;
  logic [4:0] INP0;
  logic [4:0] INP1;
  logic [2:0] INP2;
  modport master (output ps2_key, joystk1, joystk2, ORIENT, VBLK, input INP0, INP1, INP2);
  modport slave (input ps2_key, joystk1, joystk2, ORIENT, VBLK, output INP0, INP1, INP2);
endinterface

// File: rtl/gaplus_input_cond_coin_queue.sv
// gaplus_coin_queue: queues coin edges and replays them as frame-timed HOLD/GAP pulses
module gaplus_coin_queue
  import gaplus_input_pkg::*;
#(
  parameter int COIN_HOLD = 3,
  parameter int COIN_GAP = 3,
  parameter int PEND_MAX = 7
) (
  input logic MCLK,
  input logic RESET,
  input logic tick,
  input logic coin_edge,
  output logic coin_pulse
);
  localparam logic [3:0] HOLD_LAST = 4'(COIN_HOLD - 1);
  localparam logic [3:0] GAP_LAST = 4'(COIN_GAP - 1);
  localparam logic [3:0] PEND_LIM = 4'(PEND_MAX);
  coin_state_t r_state, w_state_nxt;
  logic [3:0] r_pend, r_fcnt, w_pend_nxt, w_fcnt_nxt;
  logic w_deq;
  always_comb begin
    w_state_nxt = r_state;
    w_fcnt_nxt = r_fcnt;
    w_deq = 1'b0;
    case (r_state)
      CQ_IDLE: if (r_pend != 4'd0 || coin_edge) begin
        w_deq = 1'b1;
        w_fcnt_nxt = 4'd0;
        w_state_nxt = CQ_HOLD;
      end
      CQ_HOLD: if (tick) begin
        w_fcnt_nxt = r_fcnt == HOLD_LAST ? 4'd0 : r_fcnt + 4'd1;
        w_state_nxt = r_fcnt == HOLD_LAST ? CQ_GAP : CQ_HOLD;
      end
      CQ_GAP: if (tick) begin
        w_fcnt_nxt = r_fcnt == GAP_LAST ? 4'd0 : r_fcnt + 4'd1;
        w_deq = r_fcnt == GAP_LAST && r_pend != 4'd0;
        w_state_nxt = r_fcnt != GAP_LAST ? CQ_GAP : w_deq ? CQ_HOLD : CQ_IDLE;
      end
      default: w_state_nxt = CQ_IDLE;
    endcase
    w_pend_nxt = (coin_edge && !w_deq) ? (r_pend == PEND_LIM ? r_pend : r_pend + 4'd1) :
                 (!coin_edge && w_deq) ? r_pend - 4'd1 : r_pend;
  end
  always_ff @(posedge MCLK or posedge RESET)
    if (RESET) begin
      r_state <= CQ_IDLE;
      r_pend <= 4'd0;
      r_fcnt <= 4'd0;
    end else begin
      r_state <= w_state_nxt;
      r_pend <= w_pend_nxt;
      r_fcnt <= w_fcnt_nxt;
    end
  assign coin_pulse = r_state == CQ_HOLD;
endmodule

// File: rtl/gaplus_input_cond.sv
// gaplus_input_cond: PS/2 decode, joystick merge, orientation remap and coin shaping for INP0..INP2
// Build option: define INPUT_SOCD_EN to cancel opposing directions per player.
module gaplus_input_cond
  import gaplus_input_pkg::*;
#(
  parameter int COIN_HOLD = 3,
  parameter int COIN_GAP = 3,
  parameter int PEND_MAX = 7
) (
  input logic MCLK,
  input logic RESET,
  gaplus_input_cond_if.slave io
);
  logic r_tog, r_vblk, r_coin_raw;
  logic [17:0] r_key, w_hit;
  logic [8:0] w_code;
  logic [3:0] w_stk1, w_stk2, w_p1, w_p2;
  logic w_evt, w_fire1, w_fire2, w_start1, w_start2, w_coin_raw, w_tick, w_coin_edge, w_coin;
  logic w_unused;
  assign w_unused = &{1'b0, io.joystk1[15:8], io.joystk2[15:8]};
  assign w_code = io.ps2_key[8:0];
  assign w_evt = io.ps2_key[10] ^ r_tog;
  // arrows match with or without the E0 prefix
  assign w_hit = {w_code == SC_S, w_code == SC_A, w_code == SC_G, w_code == SC_D,
                  w_code == SC_F, w_code == SC_R, w_code == SC_6, w_code == SC_5,
                  w_code == SC_2, w_code == SC_1, w_code == SC_F2, w_code == SC_F1,
                  w_code == SC_CTRL, w_code == SC_SPACE, w_code[7:0] == SC_RT,
                  w_code[7:0] == SC_LF, w_code[7:0] == SC_DN, w_code[7:0] == SC_UP};
  assign w_stk2 = {r_key[14] | io.joystk2[1], r_key[13] | io.joystk2[2],
                   r_key[15] | io.joystk2[0], r_key[12] | io.joystk2[3]};
  assign w_stk1 = {r_key[2] | io.joystk1[1], r_key[1] | io.joystk1[2],
                   r_key[3] | io.joystk1[0], r_key[0] | io.joystk1[3]} | w_stk2;
  assign w_fire2 = r_key[16] | r_key[17] | io.joystk2[4];
  assign w_fire1 = r_key[4] | r_key[5] | io.joystk1[4] | w_fire2;
  assign w_start1 = r_key[6] | r_key[8] | io.joystk1[5] | io.joystk2[5];
  assign w_start2 = r_key[7] | r_key[9] | io.joystk1[6] | io.joystk2[6];
  assign w_coin_raw = r_key[6] | r_key[7] | r_key[10] | r_key[11] | io.joystk1[7] | io.joystk2[7];
  assign w_tick = io.VBLK & ~r_vblk;
  assign w_coin_edge = w_coin_raw & ~r_coin_raw;
`ifdef INPUT_SOCD_EN
  function automatic logic [3:0] socd(input logic [3:0] s);
    return {s[3] & ~s[1], s[2] & ~s[0], s[1] & ~s[3], s[0] & ~s[2]};
  endfunction
  assign w_p1 = socd(w_stk1);
  assign w_p2 = socd(w_stk2);
`else
  assign w_p1 = w_stk1;
  assign w_p2 = w_stk2;
`endif
  always_ff @(posedge MCLK or posedge RESET)
    if (RESET) begin
      r_tog <= 1'b0;
      r_vblk <= 1'b0;
      r_coin_raw <= 1'b0;
      r_key <= '0;
      io.INP0 <= '0;
      io.INP1 <= '0;
      io.INP2 <= '0;
    end else begin
      r_tog <= io.ps2_key[10];
      r_vblk <= io.VBLK;
      r_coin_raw <= w_coin_raw;
      r_key <= w_evt ? (r_key & ~w_hit) | (w_hit & {18{io.ps2_key[9]}}) : r_key;
      io.INP0 <= {w_fire1, stkrot(io.ORIENT, w_p1)};
      io.INP1 <= {w_fire2, stkrot(io.ORIENT, w_p2)};
      io.INP2 <= {w_coin, w_start2, w_start1};
    end
  gaplus_coin_queue #(.COIN_HOLD(COIN_HOLD), .COIN_GAP(COIN_GAP), .PEND_MAX(PEND_MAX)) u_coin (
    .MCLK(MCLK),
    .RESET(RESET),
    .tick(w_tick),
    .coin_edge(w_coin_edge),
    .coin_pulse(w_coin)
  );
endmodule

// File: tb/tb_gaplus_input_cond.sv
// tb_gaplus_input_cond: directed + randomized checks of key decode, merge, remap and coin pulse shaping
module tb_gaplus_input_cond;
  localparam int FR = 40;
  localparam int COIN_HOLD = 3;
  localparam int COIN_GAP = 3;
  logic clk, rst;
  int vec, miss;
  bit keys [18];
  logic [8:0] codes [18] = '{9'h075, 9'h072, 9'h06B, 9'h074, 9'h029, 9'h014, 9'h005, 9'h006, 9'h016,
                             9'h01E, 9'h02E, 9'h036, 9'h02D, 9'h02B, 9'h023, 9'h034, 9'h01C, 9'h01B};
  logic [8:0] junk [3] = '{9'h01A, 9'h044, 9'h0F0};
  gaplus_input_cond_if bus ();
  gaplus_input_cond #(.COIN_HOLD(COIN_HOLD), .COIN_GAP(COIN_GAP), .PEND_MAX(7)) dut (
    .MCLK(clk),
    .RESET(rst),
    .io(bus)
  );
  initial begin
    clk = 0;
    forever #5 clk = ~clk;
  end
  initial begin
    int vcnt;
    vcnt = 0;
    bus.VBLK = 0;
    forever begin
      @(negedge clk);
      vcnt = (vcnt + 1) % FR;
      bus.VBLK = vcnt < 8;
    end
  end
  task automatic step();
    @(posedge clk);
    #1;
  endtask
  function automatic int key_id(input logic [8:0] c);
    key_id = -1;
    for (int i = 0; i < 18; i++)
      if (i < 4 ? c[7:0] == codes[i][7:0] : c == codes[i]) key_id = i;
  endfunction
  task automatic kev(input logic [8:0] code, input bit pr);
    int id;
    bus.ps2_key = {~bus.ps2_key[10], pr, code};
    id = key_id(code);
    if (id >= 0) keys[id] = pr;
  endtask
  function automatic void model(output logic [4:0] e0, output logic [4:0] e1, output logic [1:0] e2);
    bit u1, d1, l1, r1, f1, u2, d2, l2, r2, f2;
    logic [15:0] j1, j2;
    j1 = bus.joystk1;
    j2 = bus.joystk2;
    u2 = keys[12] | j2[3]; d2 = keys[13] | j2[2]; l2 = keys[14] | j2[1]; r2 = keys[15] | j2[0];
    f2 = keys[16] | keys[17] | j2[4];
    u1 = keys[0] | j1[3] | u2; d1 = keys[1] | j1[2] | d2; l1 = keys[2] | j1[1] | l2;
    r1 = keys[3] | j1[0] | r2; f1 = keys[4] | keys[5] | j1[4] | f2;
`ifdef INPUT_SOCD_EN
    if (u1 && d1) begin u1 = 0; d1 = 0; end
    if (l1 && r1) begin l1 = 0; r1 = 0; end
    if (u2 && d2) begin u2 = 0; d2 = 0; end
    if (l2 && r2) begin l2 = 0; r2 = 0; end
`endif
    e0 = bus.ORIENT ? {f1, u1, l1, d1, r1} : {f1, l1, d1, r1, u1};
    e1 = bus.ORIENT ? {f2, u2, l2, d2, r2} : {f2, l2, d2, r2, u2};
    e2 = {keys[7] | keys[9] | j1[6] | j2[6], keys[6] | keys[8] | j1[5] | j2[5]};
  endfunction
  task automatic chk(input string tag);
    logic [4:0] e0, e1;
    logic [1:0] e2;
    model(e0, e1, e2);
    vec++;
    assert ({bus.INP0, bus.INP1, bus.INP2[1:0]} === {e0, e1, e2}) else begin
      miss++;
      $error("FAIL %s: INP0/INP1/INP2[1:0] got %b/%b/%b want %b/%b/%b", tag,
             bus.INP0, bus.INP1, bus.INP2[1:0], e0, e1, e2);
    end
  endtask
  task automatic do_reset();
    int id;
    rst = 1;
    step();
    step();
    rst = 0;
    foreach (keys[i]) keys[i] = 0;
    if (bus.ps2_key[10]) begin
      id = key_id(bus.ps2_key[8:0]);
      if (id >= 0) keys[id] = bus.ps2_key[9];
    end
  endtask
  task automatic wait_rise();
    bit p, ok;
    ok = 0;
    p = bus.VBLK;
    for (int i = 0; i < 4 * FR && !ok; i++) begin
      step();
      ok = bus.VBLK & ~p;
      p = bus.VBLK;
    end
    vec++;
    assert (ok) else begin
      miss++;
      $error("FAIL vblk_rise: got %0d want 1", ok);
    end
  endtask
  task automatic watch_coin(input int exp_n, input int cycles, input string tag);
    int n, hi, lo;
    bit pv, pc, c, rise;
    pv = bus.VBLK;
    pc = bus.INP2[2];
    n = pc ? 1 : 0;
    hi = 0;
    lo = 0;
    repeat (cycles) begin
      step();
      c = bus.INP2[2];
      rise = bus.VBLK & ~pv;
      pv = bus.VBLK;
      if (c && !pc) begin
        if (n > 0) begin
          vec++;
          assert (lo === COIN_GAP) else begin
            miss++;
            $error("FAIL %s_gap: got %0d frames want %0d", tag, lo, COIN_GAP);
          end
        end
        n++;
        hi = 0;
      end
      if (!c && pc) begin
        vec++;
        assert (hi === COIN_HOLD) else begin
          miss++;
          $error("FAIL %s_hold: got %0d frames want %0d", tag, hi, COIN_HOLD);
        end
        lo = 0;
      end
      if (rise) begin
        if (c) hi++;
        else lo++;
      end
      pc = c;
    end
    vec++;
    assert (n === exp_n) else begin
      miss++;
      $error("FAIL %s_count: got %0d pulses want %0d", tag, n, exp_n);
    end
  endtask
  initial begin
    vec = 0;
    miss = 0;
    rst = 1;
    bus.ps2_key = '0;
    bus.joystk1 = '0;
    bus.joystk2 = '0;
    bus.ORIENT = 0;
    foreach (keys[i]) keys[i] = 0;
    step();
    step();
    vec++;
    assert ({bus.INP0, bus.INP1, bus.INP2} === 13'd0) else begin
      miss++;
      $error("FAIL reset_state: got %h want 0", {bus.INP0, bus.INP1, bus.INP2});
    end
    do_reset();
    step();
    chk("idle_after_reset");
    bus.joystk1 = 16'h0008;
    bus.ORIENT = 1;
    step();
    step();
    chk("orient_h_up");
    vec++;
    assert (bus.INP0[3:0] === 4'b1000) else begin
      miss++;
      $error("FAIL orient_h_nibble: got %b want 1000", bus.INP0[3:0]);
    end
    bus.ORIENT = 0;
    step();
    step();
    chk("orient_v_up");
    bus.joystk1 = 16'h000C;
    step();
    step();
    chk("socd_ud");
    bus.joystk1 = 16'h0003;
    bus.joystk2 = 16'h0030;
    step();
    step();
    chk("socd_lr_starts");
    bus.joystk1 = '0;
    bus.joystk2 = '0;
    kev(9'h075, 1);
    step();
    step();
    chk("key_up_press");
    kev(9'h075, 0);
    step();
    step();
    chk("key_up_release");
    bus.ps2_key = {bus.ps2_key[10], 1'b1, 9'h075};
    step();
    step();
    chk("no_toggle");
    kev(9'h01A, 1);
    step();
    step();
    chk("unmapped");
    repeat (60) begin
      int r, idx;
      logic [8:0] code;
      r = $urandom_range(0, 4);
      if (r == 0) bus.joystk1 = 16'($urandom & $urandom);
      else if (r == 1) bus.joystk2 = 16'($urandom & $urandom);
      else if (r == 2) bus.ORIENT = 1'($urandom_range(0, 1));
      else begin
        idx = $urandom_range(0, 20);
        code = idx < 18 ? codes[idx] : junk[idx - 18];
        if (idx < 4) code[8] = 1'($urandom_range(0, 1));
        kev(code, 1'($urandom_range(0, 1)));
      end
      step();
      step();
      chk("random");
    end
    bus.joystk1 = '0;
    bus.joystk2 = '0;
    bus.ORIENT = 0;
    rst = 1;
    bus.ps2_key = {1'b1, 1'b1, 9'h075};
    do_reset();
    step();
    step();
    chk("spurious_toggle");
    rst = 1;
    bus.ps2_key = '0;
    do_reset();
    step();
    chk("clean_reset");
    wait_rise();
    bus.joystk1 = 16'h0080;
    step();
    bus.joystk1 = '0;
    watch_coin(1, 10 * FR, "single");
    wait_rise();
    repeat (10) begin
      bus.joystk1 = 16'h0080;
      step();
      bus.joystk1 = '0;
      step();
    end
    watch_coin(8, 58 * FR, "burst");
    wait_rise();
    repeat (3) begin
      bus.joystk1 = 16'h0080;
      step();
      bus.joystk1 = '0;
      step();
    end
    step();
    vec++;
    assert (bus.INP2[2] === 1'b1) else begin
      miss++;
      $error("FAIL pre_reset_hold: got %b want 1", bus.INP2[2]);
    end
    #2 rst = 1;
    #1;
    vec++;
    assert (bus.INP2[2] === 1'b0) else begin
      miss++;
      $error("FAIL reset_drops_coin: got %b want 0", bus.INP2[2]);
    end
    step();
    rst = 0;
    watch_coin(0, 10 * FR, "after_reset");
    $display("== %0d vectors applied, %0d miscompares ==", vec, miss);
    $finish;
  end
endmodule
